// File: rtl/cve2_instr_bus_arbiter.sv
// rtl/cve2_instr_bus_arbiter.sv - shares the instruction memory port between fetch and one aux requester.
// Optional aux starvation preemption is enabled with `define CVE2_ARB_STARVE_EN.
module cve2_instr_bus_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned STARVE_LIMIT    = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        f_req_i,
    input  logic [31:0] f_addr_i,
    output logic        f_gnt_o,
    output logic        f_rvalid_o,
    output logic [31:0] f_rdata_o,
    output logic        f_err_o,
    input  logic        a_req_i,
    input  logic [31:0] a_addr_i,
    output logic        a_gnt_o,
    output logic        a_rvalid_o,
    output logic [31:0] a_rdata_o,
    output logic        a_err_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        busy_o,
    output logic        unexp_rvalid_o
);
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    if (STARVE_LIMIT < 1) begin : g_param_check
        $error("STARVE_LIMIT must be at least 1");
    end

    logic                       lock_q, lock_d;
    logic                       owner_q, owner_d;
    logic [MAX_OUTSTANDING-1:0] id_q, id_d;
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       unexp_q, unexp_d;

    logic owner_vld, owner_aux, owner_req, preempt;
    logic q_empty, q_full, grant, push, pop, head_aux;

    `ifdef CVE2_ARB_STARVE_EN
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_q, starve_d;

    assign preempt = (starve_q == SW'(STARVE_LIMIT));

    always_comb begin
        starve_d = '0;
        if (a_req_i && !a_gnt_o) begin
            starve_d = preempt ? starve_q : starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
    `else
    assign preempt = 1'b0;
    `endif

    // The lock pins the owner of an ungranted address phase until it is granted or withdrawn.
    always_comb begin
        owner_vld = 1'b0;
        owner_aux = 1'b0;
        if (lock_q) begin
            owner_vld = 1'b1;
            owner_aux = owner_q;
        end else if (preempt && a_req_i) begin
            owner_vld = 1'b1;
            owner_aux = 1'b1;
        end else if (f_req_i) begin
            owner_vld = 1'b1;
        end else if (a_req_i) begin
            owner_vld = 1'b1;
            owner_aux = 1'b1;
        end
    end

    assign q_empty   = (cnt_q == '0);
    assign q_full    = (cnt_q == CW'(MAX_OUTSTANDING));
    assign owner_req = owner_vld & (owner_aux ? a_req_i : f_req_i);

    assign instr_req_o  = owner_req & ~q_full;
    assign instr_addr_o = owner_vld ? ((owner_aux ? a_addr_i : f_addr_i) & 32'hFFFF_FFFC) : 32'h0;

    assign grant   = instr_req_o & instr_gnt_i;
    assign f_gnt_o = grant & ~owner_aux;
    assign a_gnt_o = grant & owner_aux;

    assign head_aux   = id_q[rd_ptr_q];
    assign f_rvalid_o = instr_rvalid_i & ~q_empty & ~head_aux;
    assign a_rvalid_o = instr_rvalid_i & ~q_empty & head_aux;
    assign f_rdata_o  = instr_rdata_i;
    assign a_rdata_o  = instr_rdata_i;
    assign f_err_o    = instr_err_i;
    assign a_err_o    = instr_err_i;

    assign busy_o         = ~q_empty | instr_req_o;
    assign unexp_rvalid_o = unexp_q;

    assign push = grant;
    assign pop  = instr_rvalid_i & ~q_empty;

    always_comb begin
        lock_d   = instr_req_o & ~instr_gnt_i;
        owner_d  = lock_d ? owner_aux : owner_q;
        id_d     = id_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        unexp_d  = unexp_q | (instr_rvalid_i & q_empty);
        if (push) begin
            id_d[wr_ptr_q] = owner_aux;
            wr_ptr_d = (wr_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q   <= 1'b0;
            owner_q  <= 1'b0;
            id_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            unexp_q  <= 1'b0;
        end else begin
            lock_q   <= lock_d;
            owner_q  <= owner_d;
            id_q     <= id_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            unexp_q  <= unexp_d;
        end
    end
endmodule

// File: tb/tb_cve2_instr_bus_arbiter.sv
// tb/tb_cve2_instr_bus_arbiter.sv - self-checking bench for cve2_instr_bus_arbiter.
// Honours `define CVE2_ARB_STARVE_EN to match the DUT build.
module tb_cve2_instr_bus_arbiter;
    localparam int MAXO = 2;
    localparam int SL   = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        f_req_i, a_req_i, instr_gnt_i, instr_rvalid_i, instr_err_i;
    logic [31:0] f_addr_i, a_addr_i, instr_rdata_i;
    logic        f_gnt_o, f_rvalid_o, f_err_o, a_gnt_o, a_rvalid_o, a_err_o;
    logic        instr_req_o, busy_o, unexp_rvalid_o;
    logic [31:0] f_rdata_o, a_rdata_o, instr_addr_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cve2_instr_bus_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SL)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .f_req_i(f_req_i), .f_addr_i(f_addr_i), .f_gnt_o(f_gnt_o),
        .f_rvalid_o(f_rvalid_o), .f_rdata_o(f_rdata_o), .f_err_o(f_err_o),
        .a_req_i(a_req_i), .a_addr_i(a_addr_i), .a_gnt_o(a_gnt_o),
        .a_rvalid_o(a_rvalid_o), .a_rdata_o(a_rdata_o), .a_err_o(a_err_o),
        .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
        .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i),
        .busy_o(busy_o), .unexp_rvalid_o(unexp_rvalid_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: in-flight owners as a queue, a pending ungranted owner, a waiting-cycle count for aux.
    bit m_q[$];
    bit m_pend_vld, m_pend_aux, m_unexp;
    int m_wait;

    always @(negedge clk) begin
        bit vld, aux, e_req, e_fg, e_ag, e_frv, e_arv;
        vld = 0;
        aux = 0;
        if (m_pend_vld) begin
            vld = 1; aux = m_pend_aux;
        end else begin
            `ifdef CVE2_ARB_STARVE_EN
            if (m_wait >= SL && a_req_i) begin vld = 1; aux = 1; end
            `endif
            if (!vld && f_req_i) vld = 1;
            else if (!vld && a_req_i) begin vld = 1; aux = 1; end
        end
        e_req = vld && (aux ? a_req_i : f_req_i) && (m_q.size() < MAXO);
        e_fg  = e_req && instr_gnt_i && !aux;
        e_ag  = e_req && instr_gnt_i && aux;
        e_frv = instr_rvalid_i && m_q.size() > 0 && m_q[0] == 1'b0;
        e_arv = instr_rvalid_i && m_q.size() > 0 && m_q[0] == 1'b1;

        chk("m_instr_req", {31'b0, instr_req_o}, {31'b0, e_req});
        chk("m_f_gnt", {31'b0, f_gnt_o}, {31'b0, e_fg});
        chk("m_a_gnt", {31'b0, a_gnt_o}, {31'b0, e_ag});
        chk("m_f_rvalid", {31'b0, f_rvalid_o}, {31'b0, e_frv});
        chk("m_a_rvalid", {31'b0, a_rvalid_o}, {31'b0, e_arv});
        chk("m_busy", {31'b0, busy_o}, {31'b0, (m_q.size() > 0) || e_req});
        chk("m_unexp", {31'b0, unexp_rvalid_o}, {31'b0, m_unexp});
        if (e_req) chk("m_addr", instr_addr_o, {(aux ? a_addr_i[31:2] : f_addr_i[31:2]), 2'b00});
        if (e_frv) begin
            chk("m_f_rdata", f_rdata_o, instr_rdata_i);
            chk("m_f_err", {31'b0, f_err_o}, {31'b0, instr_err_i});
        end
        if (e_arv) begin
            chk("m_a_rdata", a_rdata_o, instr_rdata_i);
            chk("m_a_err", {31'b0, a_err_o}, {31'b0, instr_err_i});
        end

        if (rst_i) begin
            m_q.delete();
            m_pend_vld = 0; m_pend_aux = 0; m_unexp = 0; m_wait = 0;
        end else begin
            if (instr_rvalid_i) begin
                if (m_q.size() == 0) m_unexp = 1;
                else void'(m_q.pop_front());
            end
            if (e_req && instr_gnt_i) m_q.push_back(aux);
            m_pend_vld = e_req && !instr_gnt_i;
            if (m_pend_vld) m_pend_aux = aux;
            if (a_req_i && !e_ag) m_wait = (m_wait < SL) ? m_wait + 1 : SL;
            else m_wait = 0;
        end
    end

    task automatic drv(input logic fr, input logic [31:0] fa, input logic ar, input logic [31:0] aa,
                       input logic g, input logic rv, input logic [31:0] rd, input logic er);
        f_req_i = fr; f_addr_i = fa; a_req_i = ar; a_addr_i = aa;
        instr_gnt_i = g; instr_rvalid_i = rv; instr_rdata_i = rd; instr_err_i = er;
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_i = 1'b1;
        idle();
        chk("rst_req", {31'b0, instr_req_o}, 0);
        chk("rst_unexp", {31'b0, unexp_rvalid_o}, 0);
        nxt();
        idle(); nxt();
        rst_i = 1'b0;
        idle();
        chk("rst_busy", {31'b0, busy_o}, 0);
        nxt();

        // fetch only, back-to-back grants
        drv(1, 32'h80, 0, 0, 1, 0, 0, 0);
        chk("f1_gnt", {31'b0, f_gnt_o}, 1);
        chk("f1_addr", instr_addr_o, 32'h80);
        nxt();
        drv(1, 32'h84, 0, 0, 1, 1, 32'h11, 0);
        chk("f2_addr", instr_addr_o, 32'h84);
        chk("f2_rv", {31'b0, f_rvalid_o}, 1);
        chk("f2_rdata", f_rdata_o, 32'h11);
        chk("f2_arv", {31'b0, a_rvalid_o}, 0);
        nxt();
        drv(1, 32'h88, 0, 0, 1, 1, 32'h22, 0);
        chk("f3_addr", instr_addr_o, 32'h88);
        chk("f3_rv", {31'b0, f_rvalid_o}, 1);
        nxt();
        drv(0, 0, 0, 0, 0, 1, 32'h33, 0);
        chk("f4_rv", {31'b0, f_rvalid_o}, 1);
        chk("f4_busy", {31'b0, busy_o}, 1);
        nxt();
        idle();
        chk("f5_busy", {31'b0, busy_o}, 0);
        nxt();

        // full queue, no bypass on same-cycle rvalid
        drv(1, 32'h100, 0, 0, 1, 0, 0, 0); nxt();
        drv(1, 32'h104, 0, 0, 1, 0, 0, 0); nxt();
        drv(1, 32'h108, 0, 0, 1, 0, 0, 0);
        chk("full_req", {31'b0, instr_req_o}, 0);
        nxt();
        drv(1, 32'h108, 0, 0, 1, 1, 32'h44, 0);
        chk("full_nobypass", {31'b0, instr_req_o}, 0);
        chk("full_rv", {31'b0, f_rvalid_o}, 1);
        nxt();
        drv(1, 32'h108, 0, 0, 1, 0, 0, 0);
        chk("full_resume", {31'b0, f_gnt_o}, 1);
        nxt();
        drv(0, 0, 0, 0, 0, 1, 32'h45, 0); nxt();
        drv(0, 0, 0, 0, 0, 1, 32'h46, 0); nxt();

        // lock holds aux until granted
        drv(0, 0, 1, 32'h1002, 0, 0, 0, 0);
        chk("lk_addr", instr_addr_o, 32'h1000);
        chk("lk_req", {31'b0, instr_req_o}, 1);
        nxt();
        drv(1, 32'h200, 1, 32'h1002, 0, 0, 0, 0);
        chk("lk_hold", instr_addr_o, 32'h1000);
        nxt();
        drv(1, 32'h200, 1, 32'h1002, 1, 0, 0, 0);
        chk("lk_agnt", {31'b0, a_gnt_o}, 1);
        chk("lk_fgnt", {31'b0, f_gnt_o}, 0);
        nxt();
        drv(1, 32'h200, 0, 0, 1, 0, 0, 0);
        chk("lk_fafter", {31'b0, f_gnt_o}, 1);
        nxt();
        drv(0, 0, 0, 0, 0, 1, 32'h55, 0);
        chk("lk_arv", {31'b0, a_rvalid_o}, 1);
        nxt();
        drv(0, 0, 0, 0, 0, 1, 32'h66, 0);
        chk("lk_frv", {31'b0, f_rvalid_o}, 1);
        nxt();
        // locked requester withdraws
        drv(0, 0, 1, 32'h2000, 0, 0, 0, 0); nxt();
        drv(1, 32'h300, 0, 0, 0, 0, 0, 0);
        chk("drop_req", {31'b0, instr_req_o}, 0);
        nxt();
        drv(1, 32'h300, 0, 0, 1, 0, 0, 0);
        chk("drop_fgnt", {31'b0, f_gnt_o}, 1);
        nxt();
        drv(0, 0, 0, 0, 0, 1, 32'h67, 0); nxt();

        // interleaved ownership
        drv(1, 32'h300, 0, 0, 1, 0, 0, 0); nxt();
        drv(0, 0, 1, 32'h400, 1, 0, 0, 0);
        chk("il_agnt", {31'b0, a_gnt_o}, 1);
        nxt();
        drv(0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0);
        chk("il_frv", {31'b0, f_rvalid_o}, 1);
        chk("il_fdata", f_rdata_o, 32'hDEADBEEF);
        nxt();
        drv(0, 0, 0, 0, 0, 1, 32'h12345678, 1);
        chk("il_arv", {31'b0, a_rvalid_o}, 1);
        chk("il_aerr", {31'b0, a_err_o}, 1);
        chk("il_frv2", {31'b0, f_rvalid_o}, 0);
        nxt();

        // starvation
        for (int i = 1; i <= 8; i++) begin
            drv(1, 32'h500 + 32'(4 * i), 1, 32'h600, 1, (i > 1), 32'(i), 0);
            `ifdef CVE2_ARB_STARVE_EN
            chk("st_agnt", {31'b0, a_gnt_o}, {31'b0, (i == 5)});
            `else
            chk("st_agnt", {31'b0, a_gnt_o}, 0);
            `endif
            nxt();
        end
        drv(0, 0, 0, 0, 0, 1, 32'h99, 0); nxt();

        // reset mid-transaction, then a stray response
        drv(1, 32'h700, 0, 0, 1, 0, 0, 0); nxt();
        rst_i = 1'b1;
        idle(); nxt();
        rst_i = 1'b0;
        drv(0, 0, 0, 0, 0, 1, 32'h77, 0);
        chk("ux_frv", {31'b0, f_rvalid_o}, 0);
        chk("ux_arv", {31'b0, a_rvalid_o}, 0);
        nxt();
        idle();
        chk("ux_set", {31'b0, unexp_rvalid_o}, 1);
        nxt();
        idle();
        chk("ux_hold", {31'b0, unexp_rvalid_o}, 1);
        nxt();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
